load_store_ctrl: RTL and testbench

//   Sequences every data-memory access from the MEM stage. It takes one load/store request per

---
 rtl/load_store_ctrl.sv | 160 ++++++++++++++++
 tb/tb_load_store_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl.sv
// Data-memory load/store sequencer: alignment check, req/ack memory port with byte enables,
// lane-replicated store data and sign/zero-extended load data, with a bus-error timeout.
module load_store_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_buserr,
    output logic        stall,
    output logic [1:0]  dbg_state_o
);

    // Handshake: an access is accepted on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so at most one access is in flight.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            misalign_q;
    logic            buserr_q;
    logic [TO_W-1:0] cnt_q;

    logic            fault_d;
    logic [3:0]      be_d;
    logic [31:0]     wdata_rep_d;
    logic [31:0]     shifted_d;
    logic [31:0]     load_data_d;
    logic [1:0]      off;

    assign off = addr_q[1:0];

    always_comb begin
        fault_d = 1'b0;
        case (req_funct3)
            3'b001, 3'b101:         fault_d = req_addr[0];
            3'b010:                 fault_d = (req_addr[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: fault_d = 1'b1;
            default:                fault_d = 1'b0;
        endcase
        // Stores have no unsigned variants.
        if (req_we && req_funct3[2]) fault_d = 1'b1;
    end

    always_comb begin
        be_d        = 4'b1111;
        wdata_rep_d = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_d        = 4'b0001 << off;
                wdata_rep_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d        = 4'b0011 << off;
                wdata_rep_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d        = 4'b1111;
                wdata_rep_d = wdata_q;
            end
        endcase
    end

    always_comb begin
        shifted_d = mem_rdata >> {off, 3'b000};
        case (funct3_q)
            3'b000:  load_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b001:  load_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  load_data_d = {24'd0, shifted_d[7:0]};
            3'b101:  load_data_d = {16'd0, shifted_d[15:0]};
            default: load_data_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rdata_q    <= 32'd0;
                        misalign_q <= fault_d;
                        buserr_q   <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= fault_d ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : load_data_d;
                        state_q <= RESP;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        buserr_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign stall        = (state_q != IDLE);
    assign mem_req      = (state_q == ACCESS);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be       = mem_req ? be_d : 4'd0;
    assign mem_wdata    = mem_req ? wdata_rep_d : 32'd0;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : 32'd0;
    assign rsp_misalign = rsp_valid & misalign_q;
    assign rsp_buserr   = rsp_valid & buserr_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl with a short timeout so bus-error aborts are quick.
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_buserr;
    logic        stall;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    load_store_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
        .rsp_buserr(rsp_buserr), .stall(stall), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ack_after = number of mem_req cycles before ack.
    task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_after,
                             input logic exp_fault, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int exp_req,
                             input logic [31:0] exp_rdata, input logic exp_buserr);
        int req_cyc;
        check_val({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_cyc   = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            if (mem_req) begin
                if (req_cyc == 0) begin
                    check_val({name, ".addr"}, mem_addr, {addr[31:2], 2'b00});
                    check_val({name, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
                    check_val({name, ".we"}, {31'd0, mem_we}, {31'd0, we});
                    check_val({name, ".stall"}, {31'd0, stall}, 32'd1);
                    if (we) check_val({name, ".wdata"}, mem_wdata, exp_wdata);
                end
                mem_ack   = (req_cyc == ack_after);
                mem_rdata = rdata;
                req_cyc++;
            end
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check_val({name, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_val({name, ".req_cycles"}, req_cyc, exp_req);
        check_val({name, ".rdata"}, rsp_rdata, exp_rdata);
        check_val({name, ".misalign"}, {31'd0, rsp_misalign}, {31'd0, exp_fault});
        check_val({name, ".buserr"}, {31'd0, rsp_buserr}, {31'd0, exp_buserr});
        check_val({name, ".mem_req_in_resp"}, {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check_val({name, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check_val({name, ".stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("reset.ready", {31'd0, req_ready}, 32'd1);
        check_val("reset.mem_req", {31'd0, mem_req}, 32'd0);
        check_val("reset.stall", {31'd0, stall}, 32'd0);
        check_val("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("reset.be", {28'd0, mem_be}, 32'd0);
        check_val("reset.rdata", rsp_rdata, 32'd0);

        //        name    we    f3      addr          wdata         rdata         ack flt be       wdata_exp     req rdata_exp     berr
        do_access("lb",   1'b0, 3'b000, 32'h00000103, 32'd0,        32'h80FFFFFF, 0, 1'b0, 4'b1000, 32'd0,        1, 32'hFFFFFF80, 1'b0);
        do_access("lbu",  1'b0, 3'b100, 32'h00000103, 32'd0,        32'h80FFFFFF, 0, 1'b0, 4'b1000, 32'd0,        1, 32'h00000080, 1'b0);
        do_access("lhu",  1'b0, 3'b101, 32'h00000202, 32'd0,        32'hBEEF1234, 0, 1'b0, 4'b1100, 32'd0,        1, 32'h0000BEEF, 1'b0);
        do_access("lh",   1'b0, 3'b001, 32'h00000202, 32'd0,        32'hBEEF1234, 1, 1'b0, 4'b1100, 32'd0,        2, 32'hFFFFBEEF, 1'b0);
        do_access("lb_p", 1'b0, 3'b000, 32'h00000101, 32'd0,        32'h00007F00, 0, 1'b0, 4'b0010, 32'd0,        1, 32'h0000007F, 1'b0);
        do_access("lh_0", 1'b0, 3'b001, 32'h00000010, 32'd0,        32'h00008001, 0, 1'b0, 4'b0011, 32'd0,        1, 32'hFFFF8001, 1'b0);
        do_access("sh",   1'b1, 3'b001, 32'h00000006, 32'h0000A55A, 32'hDEADBEEF, 3, 1'b0, 4'b1100, 32'hA55AA55A, 4, 32'd0,        1'b0);
        do_access("sb",   1'b1, 3'b000, 32'h00000011, 32'h123456C3, 32'hDEADBEEF, 0, 1'b0, 4'b0010, 32'hC3C3C3C3, 1, 32'd0,        1'b0);
        do_access("sw",   1'b1, 3'b010, 32'h00000020, 32'hCAFEF00D, 32'd0,        2, 1'b0, 4'b1111, 32'hCAFEF00D, 3, 32'd0,        1'b0);
        do_access("lw_m", 1'b0, 3'b010, 32'h00000102, 32'd0,        32'h11111111, 0, 1'b1, 4'b0000, 32'd0,        0, 32'd0,        1'b0);
        do_access("f011", 1'b0, 3'b011, 32'h00000100, 32'd0,        32'h11111111, 0, 1'b1, 4'b0000, 32'd0,        0, 32'd0,        1'b0);
        do_access("lh_m", 1'b0, 3'b001, 32'h00000101, 32'd0,        32'h11111111, 0, 1'b1, 4'b0000, 32'd0,        0, 32'd0,        1'b0);
        do_access("sbu",  1'b1, 3'b100, 32'h00000100, 32'h000000FF, 32'd0,        0, 1'b1, 4'b0000, 32'd0,        0, 32'd0,        1'b0);
        do_access("sw_m", 1'b1, 3'b010, 32'h00000101, 32'h000000FF, 32'd0,        0, 1'b1, 4'b0000, 32'd0,        0, 32'd0,        1'b0);
        do_access("tout", 1'b0, 3'b010, 32'h00000040, 32'd0,        32'h55555555, 99, 1'b0, 4'b1111, 32'd0,       4, 32'd0,        1'b1);
        do_access("lw",   1'b0, 3'b010, 32'h00000044, 32'd0,        32'h12345678, 0, 1'b0, 4'b1111, 32'd0,        1, 32'h12345678, 1'b0);

        // Reset while an access is outstanding.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h00000080;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("arst.mem_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("arst.mem_req", {31'd0, mem_req}, 32'd0);
        check_val("arst.stall", {31'd0, stall}, 32'd0);
        check_val("arst.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("arst.late_ack", {31'd0, rsp_valid}, 32'd0);
        end
        mem_ack = 1'b0;
        do_access("post", 1'b0, 3'b100, 32'h00000082, 32'd0, 32'h00A50000, 0, 1'b0, 4'b0100, 32'd0, 1, 32'h000000A5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
